// File: rtl/add_tree_pipe.sv
// add_tree_pipe: pipelined N-operand adder tree, one register stage per level.
// Define ADD_TREE_SIGNED_EN for two's-complement operands and sum.
module add_tree_pipe #(
    parameter int N = 4,
    parameter int n = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N*n-1:0]             din,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [n+$clog2(N)-1:0]     S
);

    localparam int L  = $clog2(N);
    localparam int SW = n + L;

    logic [SW-1:0] lvl    [L+1][2*N];
    logic [SW-1:0] data_q [L][N];
    logic [SW-1:0] data_d [L][N];
    logic [L-1:0]  vld_q;
    logic [L-1:0]  vld_d;
    logic          adv;

    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

    // Slots past a level's live count stay zero, so an odd tail adds zero
    // and passes through unchanged.
    always_comb begin
        for (int j = 0; j <= L; j++) begin
            for (int k = 0; k < 2*N; k++) begin
                lvl[j][k] = '0;
            end
        end
        for (int k = 0; k < N; k++) begin
`ifdef ADD_TREE_SIGNED_EN
            lvl[0][k] = {{L{din[k*n+n-1]}}, din[k*n +: n]};
`else
            lvl[0][k] = {{L{1'b0}}, din[k*n +: n]};
`endif
        end
        for (int j = 0; j < L; j++) begin
            for (int k = 0; k < N; k++) begin
                lvl[j+1][k] = data_q[j][k];
            end
        end
    end

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (adv) begin
            vld_d[0] = in_valid;
            for (int j = 1; j < L; j++) begin
                vld_d[j] = vld_q[j-1];
            end
            for (int j = 0; j < L; j++) begin
                for (int k = 0; k < N; k++) begin
                    data_d[j][k] = lvl[j][2*k] + lvl[j][2*k+1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int j = 0; j < L; j++) begin
                for (int k = 0; k < N; k++) begin
                    data_q[j][k] <= '0;
                end
            end
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign out_valid = vld_q[L-1];
    assign S         = data_q[L-1][0];

endmodule
